trigger_sequencer: RTL and testbench

//  Parametrised trigger controller for waveform playback: synchronises an external trigger,

---
 rtl/trigger_sequencer_if.sv | 31 +++
 rtl/trigger_sequencer.sv | 140 ++++++++++++++
 tb/tb_trigger_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_if.sv
// Signal bundle between the trigger source / playback control side and the
// trigger sequencer. The sequencer connects through the slave modport.
interface trigger_sequencer_if #(
    parameter int DLY_W  = 34,
    parameter int AUTO_W = 24,
    parameter int MISS_W = 8
);
    logic              Trig_In;
    logic              Edge_Sel;
    logic [1:0]        Mode;
    logic              Arm;
    logic [DLY_W-1:0]  Delay_Vin;
    logic [DLY_W-1:0]  Holdoff_Vin;
    logic [AUTO_W-1:0] Auto_Vin;
    logic              Ending_Sin;
    logic              Trig_Ctrl_Sout;
    logic              Trig_Start;
    logic              Auto_Fired;
    logic [2:0]        State_Out;
    logic [MISS_W-1:0] Missed_Cnt;

    modport master (
        output Trig_In, Edge_Sel, Mode, Arm, Delay_Vin, Holdoff_Vin, Auto_Vin, Ending_Sin,
        input  Trig_Ctrl_Sout, Trig_Start, Auto_Fired, State_Out, Missed_Cnt
    );

    modport slave (
        input  Trig_In, Edge_Sel, Mode, Arm, Delay_Vin, Holdoff_Vin, Auto_Vin, Ending_Sin,
        output Trig_Ctrl_Sout, Trig_Start, Auto_Fired, State_Out, Missed_Cnt
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Trigger controller for waveform playback: synchronised edge detect, programmable
// delay, playback gating until Ending_Sin, holdoff, with OFF/NORMAL/SINGLE/AUTO modes.
module trigger_sequencer #(
    parameter int DLY_W  = 34,
    parameter int AUTO_W = 24,
    parameter int MISS_W = 8
) (
    input  logic                Clock,
    input  logic                Rst_n,
    trigger_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_SINGLE = 2'd2;
    localparam logic [1:0] M_AUTO   = 2'd3;

    function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
        return (v == '1) ? v : v + MISS_W'(1);
    endfunction

    function automatic logic [AUTO_W-1:0] sat_inc_tmr(input logic [AUTO_W-1:0] v);
        return (v == '1) ? v : v + AUTO_W'(1);
    endfunction

    logic              sync_p0, sync_p1, sync_p2, hit;
    logic [2:0]        state, state_nxt, exit_state;
    logic [DLY_W-1:0]  dly_cnt, dly_cnt_nxt, hold_cnt, hold_cnt_nxt;
    logic [AUTO_W-1:0] auto_tmr;
    logic              auto_pend, auto_pend_nxt;
    logic              timeout, enter_run;
    logic              trig_ctrl, trig_start, auto_fired;
    logic [MISS_W-1:0] missed;

    // Synchroniser, edge register and registered edge-detect pulse
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            hit     <= 1'b0;
        end else begin
            sync_p0 <= bus.Trig_In;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            hit     <= bus.Edge_Sel ? (sync_p2 & ~sync_p1) : (sync_p1 & ~sync_p2);
        end
    end

    // Timer value N means N cycles elapsed since ARMED entry; Auto_Vin=0 behaves like 1.
    assign timeout    = (bus.Mode == M_AUTO) &&
                        (({1'b0, auto_tmr} + (AUTO_W+1)'(1)) >= {1'b0, bus.Auto_Vin});
    assign exit_state = (bus.Mode == M_SINGLE) ? S_IDLE : S_ARMED;

    always_comb begin
        state_nxt     = state;
        dly_cnt_nxt   = dly_cnt;
        hold_cnt_nxt  = hold_cnt;
        auto_pend_nxt = auto_pend;
        if (bus.Mode == M_OFF) begin
            state_nxt     = S_IDLE;
            dly_cnt_nxt   = '0;
            hold_cnt_nxt  = '0;
            auto_pend_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Mode != M_SINGLE || bus.Arm)
                        state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    // A real hit wins over a simultaneous timeout and clears the auto flag
                    if (hit || timeout) begin
                        auto_pend_nxt = ~hit;
                        dly_cnt_nxt   = bus.Delay_Vin;
                        state_nxt     = (bus.Delay_Vin == '0) ? S_RUN : S_DELAY;
                    end
                end
                S_DELAY: begin
                    dly_cnt_nxt = dly_cnt - DLY_W'(1);
                    if (dly_cnt == DLY_W'(1))
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (bus.Ending_Sin) begin
                        auto_pend_nxt = 1'b0;
                        hold_cnt_nxt  = bus.Holdoff_Vin;
                        state_nxt     = (bus.Holdoff_Vin == '0) ? exit_state : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    hold_cnt_nxt = hold_cnt - DLY_W'(1);
                    if (hold_cnt == DLY_W'(1))
                        state_nxt = exit_state;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign enter_run = (state_nxt == S_RUN) && (state != S_RUN);

    // Sequencer state, counters and registered outputs
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            dly_cnt    <= '0;
            hold_cnt   <= '0;
            auto_tmr   <= '0;
            auto_pend  <= 1'b0;
            trig_ctrl  <= 1'b0;
            trig_start <= 1'b0;
            auto_fired <= 1'b0;
            missed     <= '0;
        end else begin
            state      <= state_nxt;
            dly_cnt    <= dly_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            auto_pend  <= auto_pend_nxt;
            auto_tmr   <= (state == S_ARMED && state_nxt == S_ARMED) ? sat_inc_tmr(auto_tmr) : '0;
            trig_ctrl  <= (state_nxt == S_RUN);
            trig_start <= enter_run;
            auto_fired <= enter_run && auto_pend_nxt;
            if (hit && (state == S_DELAY || state == S_RUN || state == S_HOLDOFF))
                missed <= sat_inc_miss(missed);
        end
    end

    assign bus.Trig_Ctrl_Sout = trig_ctrl;
    assign bus.Trig_Start     = trig_start;
    assign bus.Auto_Fired     = auto_fired;
    assign bus.State_Out      = state;
    assign bus.Missed_Cnt     = missed;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a timestamp-based reference model of the sequencing rules.
module tb_trigger_sequencer;
    localparam int DLY_W  = 34;
    localparam int AUTO_W = 24;
    localparam int MISS_W = 8;

    logic Clock = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clock = ~Clock;

    trigger_sequencer_if #(.DLY_W(DLY_W), .AUTO_W(AUTO_W), .MISS_W(MISS_W)) trg_if ();
    trigger_sequencer_if #(.DLY_W(DLY_W), .AUTO_W(AUTO_W), .MISS_W(2))      trg_if2 ();

    trigger_sequencer #(.DLY_W(DLY_W), .AUTO_W(AUTO_W), .MISS_W(MISS_W)) dut (
        .Clock (Clock), .Rst_n (Rst_n), .bus (trg_if.slave));
    trigger_sequencer #(.DLY_W(DLY_W), .AUTO_W(AUTO_W), .MISS_W(2)) dut2 (
        .Clock (Clock), .Rst_n (Rst_n), .bus (trg_if2.slave));

    assign trg_if2.Trig_In     = trg_if.Trig_In;
    assign trg_if2.Edge_Sel    = trg_if.Edge_Sel;
    assign trg_if2.Mode        = trg_if.Mode;
    assign trg_if2.Arm         = trg_if.Arm;
    assign trg_if2.Delay_Vin   = trg_if.Delay_Vin;
    assign trg_if2.Holdoff_Vin = trg_if.Holdoff_Vin;
    assign trg_if2.Auto_Vin    = trg_if.Auto_Vin;
    assign trg_if2.Ending_Sin  = trg_if.Ending_Sin;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus for the current cycle
    logic              t_trig, t_esel, t_arm, t_end;
    logic [1:0]        t_mode;
    logic [DLY_W-1:0]  t_delay, t_hold;
    logic [AUTO_W-1:0] t_auto;

    // Reference model: phase plus absolute cycle stamps of scheduled events
    longint n;
    int     m_ph;
    longint arm_at, run_at, hold_end, run_first;
    bit     fired;
    longint missed_raw;
    bit     pin_q[$];
    bit     es_q[$];

    longint last_start, last_rise;
    bit     last_auto, prev_ctrl;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, n, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input bit hit);
        int nph;
        bit to;
        if (hit && m_ph >= 2) missed_raw++;
        nph = m_ph;
        if (t_mode == 2'd0) nph = 0;
        else begin
            case (m_ph)
                0: if (t_mode != 2'd2 || t_arm) begin nph = 1; arm_at = n + 1; end
                1: begin
                    to = (t_mode == 2'd3) && (n - arm_at + 1 >= longint'(t_auto));
                    if (hit || to) begin
                        fired = !hit;
                        if (t_delay == 0) begin nph = 3; run_first = n + 1; end
                        else begin nph = 2; run_at = n + 1 + longint'(t_delay); end
                    end
                end
                2: if (n + 1 == run_at) begin nph = 3; run_first = n + 1; end
                3: if (t_end) begin
                    if (t_hold == 0) begin nph = (t_mode == 2'd2) ? 0 : 1; arm_at = n + 1; end
                    else begin nph = 4; hold_end = n + 1 + longint'(t_hold); end
                end
                4: if (n + 1 == hold_end) begin nph = (t_mode == 2'd2) ? 0 : 1; arm_at = n + 1; end
                default: nph = 0;
            endcase
        end
        m_ph = nph;
    endtask

    task automatic drive();
        trg_if.Trig_In     = t_trig;
        trg_if.Edge_Sel    = t_esel;
        trg_if.Mode        = t_mode;
        trg_if.Arm         = t_arm;
        trg_if.Delay_Vin   = t_delay;
        trg_if.Holdoff_Vin = t_hold;
        trg_if.Auto_Vin    = t_auto;
        trg_if.Ending_Sin  = t_end;
    endtask

    // Called #1 after the edge that starts cycle n
    task automatic cycle();
        bit hit, exp_start;
        exp_start = (m_ph == 3) && (run_first == n);
        check_eq("state",   trg_if.State_Out,      m_ph);
        check_eq("ctrl",    trg_if.Trig_Ctrl_Sout, m_ph == 3);
        check_eq("start",   trg_if.Trig_Start,     exp_start);
        check_eq("auto",    trg_if.Auto_Fired,     exp_start && fired);
        check_eq("missed",  trg_if.Missed_Cnt,     sat(missed_raw, 255));
        check_eq("missed2", trg_if2.Missed_Cnt,    sat(missed_raw, 3));
        if (trg_if.Trig_Start) begin last_start = n; last_auto = trg_if.Auto_Fired; end
        if (trg_if.Trig_Ctrl_Sout && !prev_ctrl) last_rise = n;
        prev_ctrl = trg_if.Trig_Ctrl_Sout;
        drive();
        // Pin edge between cycles n-4 and n-3, polarity chosen by Edge_Sel of cycle n-1
        hit = (pin_q[0] != pin_q[1]) && (pin_q[1] == !es_q[3]);
        pin_q.push_back(t_trig); void'(pin_q.pop_front());
        es_q.push_back(t_esel);  void'(es_q.pop_front());
        model_step(hit);
        t_arm = 1'b0;
        t_end = 1'b0;
        @(posedge Clock);
        #1;
        n++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic wait_start(input int budget);
        last_start = -1;
        for (int i = 0; i < budget && last_start < 0; i++) cycle();
    endtask

    task automatic do_reset();
        Rst_n  = 1'b0;
        t_trig = 1'b0; t_arm = 1'b0; t_end = 1'b0; t_mode = 2'd0;
        drive();
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Rst_n = 1'b1;
        n = 0; m_ph = 0; fired = 0; missed_raw = 0;
        arm_at = 0; run_at = -1; hold_end = -1; run_first = -1;
        pin_q = '{0, 0, 0, 0};
        es_q  = '{0, 0, 0, 0};
        prev_ctrl = 1'b0;
    endtask

    initial begin
        longint e, a2, raw0;
        t_esel = 1'b0; t_delay = '0; t_hold = '0; t_auto = '0;
        do_reset();
        check_eq("rst_state", trg_if.State_Out, 0);
        check_eq("rst_ctrl",  trg_if.Trig_Ctrl_Sout, 0);
        check_eq("rst_miss",  trg_if.Missed_Cnt, 0);

        // NORMAL, delay 5: start 3 + 1 + 5 cycles after the pin edge
        t_mode = 2'd1; t_delay = 5; t_hold = 3;
        run(3);
        e = n; t_trig = 1'b1;
        wait_start(30);
        check_eq("t1_start", last_start, e + 9);
        run(3); t_end = 1'b1; run(1);
        check_eq("t1_ctrl_low", trg_if.Trig_Ctrl_Sout, 0);
        run(6);

        // Zero delay and zero holdoff
        t_delay = 0; t_hold = 0; t_trig = 1'b0;
        run(5);
        e = n; t_trig = 1'b1;
        wait_start(20);
        check_eq("t2_ctrl_rise", last_rise, e + 4);
        t_end = 1'b1; run(1);
        check_eq("t2_rearmed", trg_if.State_Out, 1);

        // SINGLE: edges without Arm are ignored, one armed run returns to IDLE
        t_mode = 2'd0; run(1);
        t_mode = 2'd2; run(2);
        for (int i = 0; i < 6; i++) begin t_trig = ~t_trig; run(4); end
        run(4);
        check_eq("t3_idle_no_arm", trg_if.State_Out, 0);
        t_arm = 1'b1; run(1);
        t_trig = 1'b0; run(4); t_trig = 1'b1;
        wait_start(20);
        check_eq("t3_started", last_start >= 0, 1);
        t_hold = 4; run(2); t_end = 1'b1; run(1);
        check_eq("t3_holdoff", trg_if.State_Out, 4);
        run(4);
        check_eq("t3_back_idle", trg_if.State_Out, 0);

        // AUTO timeout of 10 cycles, repeated after a holdoff
        t_mode = 2'd3; t_auto = 10; t_delay = 0; t_hold = 2;
        run(1);
        e = n;
        wait_start(30);
        check_eq("t4_auto_start", last_start, e + 10);
        check_eq("t4_auto_flag", last_auto, 1);
        run(2); t_end = 1'b1; run(1);
        a2 = n + 2;
        wait_start(40);
        check_eq("t4_auto_again", last_start, a2 + 10);

        // Falling-edge trigger, then extra edges during RUN are only counted
        t_hold = 0; t_end = 1'b1; t_mode = 2'd1; run(1);
        t_esel = 1'b1; run(4);
        e = n; t_trig = 1'b0;
        wait_start(20);
        check_eq("t5_fall_start", last_start, e + 4);
        raw0 = missed_raw;
        for (int i = 0; i < 8; i++) begin t_trig = ~t_trig; run(4); end
        run(4);
        check_eq("t5_no_retrig", trg_if.State_Out, 3);
        check_eq("t5_missed", trg_if.Missed_Cnt, sat(raw0 + 4, 255));
        check_eq("t5_sat2", trg_if2.Missed_Cnt, 3);

        // Mode OFF during DELAY, then asynchronous reset during RUN
        t_end = 1'b1; t_delay = 20; run(1);
        t_trig = 1'b1; run(4); t_trig = 1'b0; run(6);
        check_eq("t6_delay", trg_if.State_Out, 2);
        t_mode = 2'd0; run(1);
        check_eq("t6_off_idle", trg_if.State_Out, 0);
        t_mode = 2'd1; t_delay = 0; run(2);
        t_trig = 1'b1; run(4); t_trig = 1'b0;
        wait_start(20);
        run(2);
        check_eq("t6_in_run", trg_if.State_Out, 3);
        #2 Rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ctrl",  trg_if.Trig_Ctrl_Sout, 0);
        check_eq("t6_rst_state", trg_if.State_Out, 0);
        check_eq("t6_rst_miss",  trg_if.Missed_Cnt, 0);
        check_eq("t6_rst_start", trg_if.Trig_Start, 0);
        do_reset();

        // Random traffic against the model
        t_mode = 2'd1; t_esel = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0)  t_trig = ~t_trig;
            if ($urandom_range(0, 7) == 0)  t_end  = 1'b1;
            if ($urandom_range(0, 9) == 0)  t_arm  = 1'b1;
            if ($urandom_range(0, 79) == 0) t_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) t_esel = ~t_esel;
            if ($urandom_range(0, 19) == 0) begin
                t_delay = DLY_W'($urandom_range(0, 6));
                t_hold  = DLY_W'($urandom_range(0, 5));
                t_auto  = AUTO_W'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", n);
        $fatal(1);
    end

endmodule
